pwm_multi: RTL and testbench

- Parametrised N-channel PWM generator, successor to the single-channel hsync-driven PWM block.
- Fully synchronous to one clock. Owns its own period counter instead of taking an external count and hsync.
- Double-buffered per-channel duty and a shared period register; new values take effect only at a period boundary, so there are no glitches.
- Sits between the pixel/data register file (writer side) and the PWM output pads, and emits a period-start sync pulse.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_channel.sv | 51 +++++
 rtl/pwm_multi.sv | 75 +++++++
 tb/tb_pwm_multi.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_DWIDTH = 8;
  localparam int unsigned PWM_NCH    = 4;

  function automatic int unsigned chw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow/active), compare against the
// shared counter, registered output with per-channel polarity.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DWIDTH = PWM_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [DWIDTH-1:0] cnt,
  input  logic              pol,
  input  logic              gate,
  output logic              out
);

  logic [DWIDTH-1:0] duty_sh_q;
  logic [DWIDTH-1:0] duty_act_q;
  logic              out_q;
  logic              out_d;
  logic              live_q;

  always_comb begin
    out_d = pol ^ (gate && (duty_act_q > cnt));
  end

  // load copies the pre-write shadow, so a write on the boundary edge waits a period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      out_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      if (wr) begin
        duty_sh_q <= wr_data;
      end
      if (load) begin
        duty_act_q <= duty_sh_q;
      end
      out_q  <= out_d;
      live_q <= 1'b1;
    end
  end

  // Until the first registered update the pad follows the idle level directly.
  assign out = live_q ? out_q : pol;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator: shared period counter, period shadow, write
// decode, period-start sync and out-of-range write error pulse.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int DWIDTH = PWM_DWIDTH,
  parameter int NCH    = PWM_NCH,
  parameter int CHW    = chw(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DWIDTH-1:0] period,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [NCH-1:0]    pol,
  output logic [NCH-1:0]    out,
  output logic              sync,
  output logic              wr_err
);

  localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

  logic [DWIDTH-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] per_act_q, per_act_d;
  logic              sync_q, sync_d;
  logic              wr_err_q, wr_err_d;
  logic              run;
  logic              load;

  // Disabled or zero period both collapse into continuous reload with idle outputs.
  always_comb begin
    run       = en && (per_act_q != '0);
    load      = !run || (cnt_q == per_act_q - DWIDTH'(1));
    cnt_d     = load ? '0 : cnt_q + DWIDTH'(1);
    per_act_d = load ? period : per_act_q;
    sync_d    = run && (cnt_q == '0);
    wr_err_d  = wr_en && ({1'b0, wr_ch} >= NCH_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      per_act_q <= '0;
      sync_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_act_q <= per_act_d;
      sync_q    <= sync_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign sync   = sync_q;
  assign wr_err = wr_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(
      .DWIDTH(DWIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .wr     (wr_en && (wr_ch == CHW'(i))),
      .wr_data(wr_data),
      .cnt    (cnt_q),
      .pol    (pol[i]),
      .gate   (run),
      .out    (out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: scenario tasks plus a randomized run,
// compared against a period/duty reference model.
module tb_pwm_multi;

  localparam int DW  = 8;
  localparam int NCH = 5;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [DW-1:0]  period;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [DW-1:0]  wr_data;
  logic [NCH-1:0] pol;
  logic [NCH-1:0] out;
  logic           sync;
  logic           wr_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_multi #(.DWIDTH(DW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .pol(pol), .out(out), .sync(sync), .wr_err(wr_err)
  );

  // Reference model: position within the period, active length min(duty, period).
  int             m_cnt, m_per;
  int             m_sh [NCH];
  int             m_act[NCH];
  logic [NCH-1:0] m_out;
  logic           m_sync, m_err, m_live;
  bit             m_run;
  logic [NCH-1:0] m_exp;
  assign m_exp = m_live ? m_out : pol;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_per = 0; m_out = '0; m_sync = 0; m_err = 0; m_live = 0;
      for (int i = 0; i < NCH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    end else begin
      m_run  = en && (m_per != 0);
      m_sync = m_run && (m_cnt == 0);
      for (int i = 0; i < NCH; i++)
        m_out[i] = pol[i] ^ (m_run && (m_cnt < ((m_act[i] < m_per) ? m_act[i] : m_per)));
      m_err = wr_en && (int'(wr_ch) >= NCH);
      if (!m_run || m_cnt == m_per - 1) begin
        for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
        m_per = int'(period);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (wr_en && int'(wr_ch) < NCH) m_sh[wr_ch] = int'(wr_data);
      m_live = 1;
    end
  end

  // Window measurement (no checking here): active cycles per channel from a sync pulse.
  int w_act[NCH];
  int w_sync;
  bit w_tmo;
  logic [NCH-1:0] w_first;

  task automatic measure(input int len);
    for (int n = 0; n < 40 && sync !== 1'b1; n++) @(negedge clk);
    w_tmo  = (sync !== 1'b1);
    w_sync = 0;
    w_first = out;
    for (int i = 0; i < NCH; i++) w_act[i] = 0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      w_sync += int'(sync);
      for (int i = 0; i < NCH; i++) w_act[i] += int'(out[i] ^ pol[i]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; en = 0; period = '0; wr_en = 0; wr_ch = '0; wr_data = '0;
    pol = NCH'($urandom);
    #2;
    vectors++;
    if (out !== pol || sync !== 1'b0 || wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state out=%b sync=%b wr_err=%b want out=%b sync=0 wr_err=0", out, sync, wr_err, pol);
    end
    @(negedge clk);
    pol = NCH'($urandom);
    #1;
    vectors++;
    if (out !== pol) begin
      miscompares++;
      $display("FAIL reset_pol_follow out=%b want %b", out, pol);
    end
    rst = 0;
    @(negedge clk);
    vectors++;
    if (out !== m_exp || sync !== m_sync || wr_err !== m_err) begin
      miscompares++;
      $display("FAIL reset_release out=%b/%b sync=%b/%b err=%b/%b", out, m_exp, sync, m_sync, wr_err, m_err);
    end
  endtask

  task automatic test_basic();
    int duty[NCH];
    duty = '{3, 0, 10, 15, 6};
    en = 0; period = 8'd10; pol = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_en = 1; wr_ch = CHW'(c); wr_data = DW'(duty[c]);
      @(negedge clk);
    end
    wr_en = 0; en = 1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      vectors++;
      if (out !== m_exp || sync !== m_sync || wr_err !== m_err) begin
        miscompares++;
        $display("FAIL basic_model t=%0t out=%b/%b sync=%b/%b err=%b/%b", $time, out, m_exp, sync, m_sync, wr_err, m_err);
      end
    end
    for (int rep = 0; rep < 2; rep++) begin
      measure(10);
      vectors++;
      if (w_tmo || w_act[0] != 3 || w_act[1] != 0 || w_act[2] != 10 || w_act[3] != 10 ||
          w_act[4] != 6 || w_sync != 1 || w_first[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_window tmo=%0b act=%0d,%0d,%0d,%0d,%0d sync=%0d out0@sync=%b want 3,0,10,10,6 sync=1 out0@sync=1",
                 w_tmo, w_act[0], w_act[1], w_act[2], w_act[3], w_act[4], w_sync, w_first[0]);
      end
    end
  endtask

  task automatic test_multi_write();
    int vals[3];
    vals = '{3, 7, 5};
    for (int n = 0; n < 30 && m_cnt != 2; n++) @(negedge clk);
    vectors++;
    if (m_cnt != 2) begin
      miscompares++;
      $display("FAIL multi_wait timeout cnt=%0d want 2", m_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      wr_en = 1; wr_ch = '0; wr_data = DW'(vals[k]);
      @(negedge clk);
      vectors++;
      if (out !== m_exp || sync !== m_sync) begin
        miscompares++;
        $display("FAIL multi_model out=%b/%b sync=%b/%b", out, m_exp, sync, m_sync);
      end
    end
    wr_en = 0;
    measure(10);
    vectors++;
    if (w_tmo || w_act[0] != 5) begin
      miscompares++;
      $display("FAIL multi_lastwins tmo=%0b act0=%0d want 5", w_tmo, w_act[0]);
    end
  endtask

  task automatic test_boundary_write();
    for (int n = 0; n < 30 && !(m_cnt == 9 && m_per == 10); n++) @(negedge clk);
    vectors++;
    if (!(m_cnt == 9 && m_per == 10)) begin
      miscompares++;
      $display("FAIL bnd_wait timeout cnt=%0d per=%0d want 9,10", m_cnt, m_per);
    end
    wr_en = 1; wr_ch = '0; wr_data = 8'd8;
    @(negedge clk);
    wr_en = 0;
    measure(10);
    vectors++;
    if (w_tmo || w_act[0] != 5) begin
      miscompares++;
      $display("FAIL bnd_first tmo=%0b act0=%0d want 5", w_tmo, w_act[0]);
    end
    measure(10);
    vectors++;
    if (w_tmo || w_act[0] != 8) begin
      miscompares++;
      $display("FAIL bnd_second tmo=%0b act0=%0d want 8", w_tmo, w_act[0]);
    end
  endtask

  task automatic test_period_change();
    int s[$];
    for (int n = 0; n < 30 && !(m_cnt == 3 && m_per == 10); n++) @(negedge clk);
    vectors++;
    if (!(m_cnt == 3 && m_per == 10)) begin
      miscompares++;
      $display("FAIL per_wait timeout cnt=%0d per=%0d want 3,10", m_cnt, m_per);
    end
    period = 8'd4;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (sync === 1'b1) s.push_back(c);
      vectors++;
      if (out !== m_exp || sync !== m_sync) begin
        miscompares++;
        $display("FAIL per_model c=%0d out=%b/%b sync=%b/%b", c, out, m_exp, sync, m_sync);
      end
    end
    vectors++;
    if (s.size() < 3 || s[0] != 8 || s[1] - s[0] != 4 || s[2] - s[1] != 4) begin
      miscompares++;
      $display("FAIL per_spacing n=%0d first=%0d gaps=%0d,%0d want first=8 gaps=4,4",
               s.size(), (s.size() > 0) ? s[0] : -1,
               (s.size() > 1) ? s[1] - s[0] : -1, (s.size() > 2) ? s[2] - s[1] : -1);
    end
    period = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (out !== m_exp || sync !== m_sync) begin
        miscompares++;
        $display("FAIL per0_model out=%b/%b sync=%b/%b", out, m_exp, sync, m_sync);
      end
    end
    vectors++;
    if (out !== pol || sync !== 1'b0) begin
      miscompares++;
      $display("FAIL per0_idle out=%b sync=%b want out=%b sync=0", out, sync, pol);
    end
  endtask

  task automatic test_enable();
    en = 0; pol = 5'b00101; period = 8'd10;
    wr_en = 1; wr_ch = 3'd0; wr_data = 8'd2;
    @(negedge clk);
    wr_ch = 3'd1; wr_data = 8'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wr_en = 0;
      vectors++;
      if (out !== 5'b00101 || sync !== 1'b0) begin
        miscompares++;
        $display("FAIL en_idle out=%b sync=%b want out=00101 sync=0", out, sync);
      end
    end
    en = 1;
    @(negedge clk);
    vectors++;
    if (sync !== 1'b1 || out !== 5'b11010) begin
      miscompares++;
      $display("FAIL en_first out=%b sync=%b want out=11010 sync=1", out, sync);
    end
    for (int c = 0; c < 25; c++) begin
      if (c == 7) en = 0;
      if (c == 10) en = 1;
      @(negedge clk);
      vectors++;
      if (out !== m_exp || sync !== m_sync) begin
        miscompares++;
        $display("FAIL en_model c=%0d out=%b/%b sync=%b/%b", c, out, m_exp, sync, m_sync);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 30 && !(m_cnt == 5 && m_per == 10); n++) @(negedge clk);
    vectors++;
    if (!(m_cnt == 5 && m_per == 10)) begin
      miscompares++;
      $display("FAIL rstmid_wait timeout cnt=%0d per=%0d", m_cnt, m_per);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (out !== pol || sync !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_immediate out=%b sync=%b want out=%b sync=0", out, sync, pol);
    end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (out !== pol || out !== m_exp || sync !== m_sync) begin
        miscompares++;
        $display("FAIL rstmid_dutyzero out=%b want %b sync=%b/%b", out, pol, sync, m_sync);
      end
    end
    wr_en = 1; wr_ch = 3'd5; wr_data = 8'd9;
    @(negedge clk);
    wr_en = 0;
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wrerr_pulse wr_err=%b want 1", wr_err);
    end
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrerr_width wr_err=%b want 0", wr_err);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      vectors++;
      if (out !== pol || wr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wrerr_nochange out=%b want %b wr_err=%b want 0", out, pol, wr_err);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      vectors++;
      if (out !== m_exp || sync !== m_sync || wr_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_model c=%0d out=%b/%b sync=%b/%b err=%b/%b", c, out, m_exp, sync, m_sync, wr_err, m_err);
      end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) period = DW'($urandom_range(0, 12));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = CHW'($urandom_range(0, 7));
      wr_data = DW'($urandom_range(0, 14));
      if ($urandom_range(0, 29) == 0) pol = NCH'($urandom);
    end
    wr_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_write();
    test_boundary_write();
    test_period_change();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
